// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and sign helper for muldiv_unit.
// Divide support is selected by MULDIV_DIV_EN in the users of this package.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Widest supported WIDTH; the helper works on 2*MAX_W bits.
  localparam int MAX_W = 64;

  typedef logic [2*MAX_W-1:0] wide_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  // Two's-complement negate when neg is set (magnitude or sign fixup).
  function automatic wide_t cond_neg(input wide_t x, input logic neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 multiply (shift-add) or divide (restoring) step.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
`endif
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opnd} : '0);

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign shl    = acc[2*WIDTH-1:WIDTH-1];
  assign borrow = shl < {1'b0, opnd};
  assign diff   = shl[WIDTH-1:0] - opnd;

  // Select multiply shift-add or divide trial-subtract result.
  always_comb begin
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt = borrow
        ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
        : {diff, acc[WIDTH-2:0], 1'b1};
    end
  end
`else
  assign acc_nxt = {sum, acc[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/DIV with HI/LO and start/busy/done handshake.
// MULDIV_DIV_EN builds the divider; without it DIV/DIVU are 1-cycle no-ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q;

  logic is_mul, is_div, is_mthi, is_mtlo, sgn;
  wide_t a_wide, b_wide, p_wide;
  logic unused_wide;

  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);
  assign sgn     = (op == OP_MULT) || (op == OP_DIV);

  assign a_wide = cond_neg(wide_t'(a), sgn & a[WIDTH-1]);
  assign b_wide = cond_neg(wide_t'(b), sgn & b[WIDTH-1]);
  assign p_wide = cond_neg(wide_t'(acc), neg_q);

  assign busy = (state != S_IDLE);

`ifdef MULDIV_DIV_EN
  logic  mode_div;
  logic  neg_r;
  wide_t q_wide, r_wide;

  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign q_wide = cond_neg(wide_t'(acc[WIDTH-1:0]), neg_q);
  assign r_wide = cond_neg(wide_t'(acc[2*WIDTH-1:WIDTH]), neg_r);
  assign unused_wide = ^{a_wide, b_wide, p_wide, q_wide, r_wide};
`else
  assign is_div = 1'b0;
  assign unused_wide = ^{a_wide, b_wide, p_wide};
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
`ifdef MULDIV_DIV_EN
    .is_div  (mode_div),
`endif
    .acc_nxt (acc_nxt)
  );

  // Control FSM: accept, iterate, sign-fix and commit HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_DIV_EN
      mode_div <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            div_zero <= 1'b0;
            unique case (1'b1)
              is_mul, is_div: begin
                acc <= {{WIDTH{1'b0}},
                        is_div ? a_wide[WIDTH-1:0]
                               : b_wide[WIDTH-1:0]};
                opnd <= is_div ? b_wide[WIDTH-1:0]
                               : a_wide[WIDTH-1:0];
                neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                neg_r    <= sgn & a[WIDTH-1];
                mode_div <= is_div;
`endif
                cnt   <= CW'(WIDTH);
                state <= S_RUN;
              end
              is_mthi: begin
                hi   <= a;
                done <= 1'b1;
              end
              is_mtlo: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
`ifdef MULDIV_DIV_EN
            if (mode_div) begin
              hi       <= r_wide[WIDTH-1:0];
              lo       <= q_wide[WIDTH-1:0];
              div_zero <= (opnd == '0);
            end else begin
              hi <= p_wide[2*WIDTH-1:WIDTH];
              lo <= p_wide[WIDTH-1:0];
            end
`else
            hi <= p_wide[2*WIDTH-1:WIDTH];
            lo <= p_wide[WIDTH-1:0];
`endif
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the single-cycle multiplier plus HI/LO pair in the execute stage of the pipelined MIPS core. It accepts signed and unsigned MULT/DIV and MTHI/MTLO requests through a start/busy/done handshake. It exposes `busy` so the hazard unit can stall MFHI/MFLO and further mul/div requests. A `flush` from branch resolution cancels an in-flight operation.

## Interface
- `WIDTH`, 32: operand width; HI and LO are WIDTH bits each; must be even and ≥ 4.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request valid; sampled only when `busy`=0.
- `op`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved and treated as no-op (accepted, `done` pulses, HI/LO unchanged).
- `a`  in  WIDTH: rs operand (dividend, multiplicand, or MTHI/MTLO data).
- `b`  in  WIDTH: rt operand (divisor, multiplier).
- `flush`  in  1: abort the in-flight operation.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse when HI/LO are committed.
- `div_zero`  out  1: sticky; set by a DIV/DIVU with `b`=0; cleared by the next accepted request.
- `hi`, `lo`  out  WIDTH: architectural HI/LO registers.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + `start` with op 0–3: latch operand magnitudes (absolute values for signed ops), latch result-sign flags, load counter with WIDTH, go to RUN.
- IDLE + `start` with op 4/5/6/7: commit in the same edge. MTHI writes `hi`; MTLO writes `lo`. Pulse `done`. Stay in IDLE.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - Decrement the counter; on the edge where it reaches 0, go to FIX.
- FIX: apply signs. Product is negated if signs differ. Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - Write `hi`/`lo`: product upper/lower, or remainder/quotient.
  - Pulse `done`; return to IDLE.
- Divide by zero: `lo` = all ones and `hi` = dividend (both sign-fixed for DIV); `div_zero` set.
- DIV with MIN / −1: `lo` = MIN, `hi` = 0. No trap.
- `flush` in RUN or FIX: return to IDLE on that edge. HI/LO are unchanged and `done` does not pulse.
- `flush` and `start` in the same IDLE cycle: flush wins and the request is dropped.
- `start` while `busy`: ignored. The hazard unit must hold the instruction.

## Timing
- Reset values: FSM = IDLE; `busy`, `done`, `div_zero` = 0; `hi`, `lo` = 0.
- Mul/div accepted at edge E0: `busy`=1 after E0 through edge E(WIDTH+1). HI/LO update and `done`=1 after E(WIDTH+1). `busy` falls in that same cycle. Latency is WIDTH+1 cycles (33 at the default width).
- MTHI/MTLO: HI/LO update and `done` after E0; `busy` stays 0.
- A new request can be accepted in the cycle `done` is high.
- Reset asserted mid-operation: immediate return to reset values with no commit.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as specified.
- `MULDIV_DIV_EN` undefined: the divide datapath is not built. DIV/DIVU are accepted as single-cycle no-ops: `done` pulses after E0, HI/LO are unchanged, `div_zero` stays 0, and `busy` is never asserted for them. Multiply behaviour is identical in both builds.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings (`OP_MULT` … `OP_MTLO`);
  - the FSM state enum;
  - a helper function for two's-complement magnitude/negate.
- Sub-module `muldiv_step`: combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide), parametrised by WIDTH. `muldiv_unit` owns the FSM, counter, sign fixup and HI/LO.

## Test plan
- Reset: assert `rst` mid-RUN → `busy`=0, `hi`=`lo`=0 immediately, and no `done` after release.
- MULT a=−3, b=7 (WIDTH=32) → after 33 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, one `done` pulse; MULTU 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE.
- DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/0 → `lo`=0xFFFFFFFF, `hi`=7, `div_zero`=1. A following MTLO clears `div_zero`.
- Flush at cycle 10 of a MULT → `busy` falls the next cycle and HI/LO keep prior values. Flush and start together in IDLE → request dropped.
- MTHI 0x1234 then MTLO 0x5678 in back-to-back cycles → `hi`=0x1234, `lo`=0x5678, `done` high two cycles, `busy` never set. A `start` during a MULT's `busy` window is ignored.
- Build without `MULDIV_DIV_EN`: DIV 10/3 → `done` after 1 cycle and HI/LO unchanged.
